// File: rtl/wfq_ftime_calc.sv
// Per-flow WFQ finish-time calculator: read previous F from the finish-time RAM,
// compute F = later(vtime, prev) + (len >> w_shift), write it back and present it downstream.
module wfq_ftime_calc #(
  parameter int N  = 13,
  parameter int L  = 11,
  parameter int FW = N + 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_flow_id,
  input  logic [L-1:0]  in_len,
  input  logic [3:0]    in_w_shift,
  input  logic [FW-1:0] in_vtime,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_flow_id,
  output logic [FW-1:0] out_ftime,
  input  logic          clr,
  output logic          busy,
  output logic          ram_we,
  output logic [N-1:0]  ram_w_addr,
  output logic [N-1:0]  ram_r_addr,
  output logic [FW-1:0] ram_din,
  input  logic [FW-1:0] ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_OUT, S_CLR} state_t;

  localparam logic [FW-1:0] HALF = {1'b1, {(FW-1){1'b0}}};

  state_t        r_state;
  logic [N-1:0]  r_flow;
  logic [L-1:0]  r_len;
  logic [3:0]    r_shift;
  logic [FW-1:0] r_vtime;
  logic          r_pend;
  logic [N-1:0]  r_cnt;
  logic [N-1:0]  r_out_flow;
  logic [FW-1:0] r_out_ftime;

  logic [FW-1:0] w_diff;
  logic          w_prev_later;
  logic [FW-1:0] w_start;
  logic [FW-1:0] w_incr;
  logic [FW-1:0] w_ftime;
  logic          w_accept;

  // Serial-number compare: prev is "later" when (vtime - prev) lands in the upper half.
  assign w_diff       = r_vtime - ram_dout;
  assign w_prev_later = (w_diff >= HALF);
  assign w_start      = w_prev_later ? ram_dout : r_vtime;
  assign w_incr       = FW'(r_len) >> r_shift;
  assign w_ftime      = w_start + w_incr;

  // A clear request arriving this cycle also blocks acceptance, so clear wins a tie.
  assign in_ready = (r_state == S_IDLE) && !r_pend && !clr;
  assign w_accept = in_valid && in_ready;

  assign busy        = r_pend || (r_state == S_CLR);
  assign out_valid   = (r_state == S_OUT);
  assign out_flow_id = r_out_flow;
  assign out_ftime   = r_out_ftime;
  assign ram_we      = (r_state == S_CALC) || (r_state == S_CLR);
  assign ram_w_addr  = (r_state == S_CLR) ? r_cnt : r_flow;
  assign ram_din     = (r_state == S_CALC) ? w_ftime : '0;
  assign ram_r_addr  = r_flow;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  // The external RAM is not reset here; a clr sweep after reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flow      <= '0;
      r_len       <= '0;
      r_shift     <= '0;
      r_vtime     <= '0;
      r_pend      <= 1'b0;
      r_cnt       <= '0;
      r_out_flow  <= '0;
      r_out_ftime <= '0;
    end else begin
      if (clr && r_state != S_CLR) r_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_cnt   <= '0;
            r_state <= S_CLR;
          end else if (w_accept) begin
            r_flow  <= in_flow_id;
            r_len   <= in_len;
            r_shift <= in_w_shift;
            r_vtime <= in_vtime;
            r_state <= S_RD;
          end
        end
        S_RD:   r_state <= S_CALC;
        S_CALC: begin
          r_out_flow  <= r_flow;
          r_out_ftime <= w_ftime;
          r_state     <= S_OUT;
        end
        S_OUT:  if (out_ready) r_state <= S_IDLE;
        S_CLR: begin
          r_cnt <= r_cnt + N'(1);
          if (r_cnt == '1) begin
            r_pend  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfq_ftime_calc.sv
// Bench for wfq_ftime_calc: behavioural finish-time RAM, expected-result queue
// filled at stimulus time and compared against results captured at each output handshake.
module tb_wfq_ftime_calc;

  localparam int N  = 13;
  localparam int L  = 11;
  localparam int FW = 16;
  localparam int DEPTH = 1 << N;

  typedef struct packed {
    logic [N-1:0]  flow;
    logic [FW-1:0] ftime;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_flow_id;
  logic [L-1:0]  in_len;
  logic [3:0]    in_w_shift;
  logic [FW-1:0] in_vtime;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_flow_id;
  logic [FW-1:0] out_ftime;
  logic          clr;
  logic          busy;
  logic          ram_we;
  logic [N-1:0]  ram_w_addr;
  logic [N-1:0]  ram_r_addr;
  logic [FW-1:0] ram_din;
  logic [FW-1:0] ram_dout;

  logic [FW-1:0] mem [DEPTH];
  logic          scramble;
  logic          poke_en;
  logic [N-1:0]  poke_addr;
  logic [FW-1:0] poke_data;
  int            wr_cnt = 0;

  exp_t exp_q[$];
  exp_t obs [64];
  int   n_obs = 0;
  int   rd = 0;
  int   checks = 0;
  int   failures = 0;

  wfq_ftime_calc #(.N(N), .L(L), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flow_id(in_flow_id),
    .in_len(in_len), .in_w_shift(in_w_shift), .in_vtime(in_vtime),
    .out_valid(out_valid), .out_ready(out_ready), .out_flow_id(out_flow_id),
    .out_ftime(out_ftime), .clr(clr), .busy(busy),
    .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model with a bench-side fill and single-entry poke port.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FW'(i * 37) | FW'(1);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (ram_we) begin
      mem[ram_w_addr] <= ram_din;
    end
    if (ram_we) wr_cnt <= wr_cnt + 1;
    ram_dout <= mem[ram_r_addr];
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      obs[n_obs % 64] <= {out_flow_id, out_ftime};
      n_obs           <= n_obs + 1;
    end
  end

  task automatic poke(input logic [N-1:0] a, input logic [FW-1:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] f, input logic [L-1:0] len, input logic [3:0] sh,
                      input logic [FW-1:0] vt, input logic [FW-1:0] ef);
    int t = 0;
    exp_q.push_back('{flow: f, ftime: ef});
    in_valid = 1'b1; in_flow_id = f; in_len = len; in_w_shift = sh; in_vtime = vt;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready=%0b expected 1 within %0d cycles", in_ready, t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((n_obs - rd) < exp_q.size() && t < 200) begin @(posedge clk); #1; t++; end
    if ((n_obs - rd) < exp_q.size()) begin
      checks++; failures++;
      $display("FAIL drain_timeout: results=%0d expected=%0d", n_obs - rd, exp_q.size());
      exp_q.delete();
      rd = n_obs;
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scramble = 1'b1;
    repeat (2) @(posedge clk);
    #1; scramble = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, ram_we} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl: got ready/valid/busy/we=%b expected 1000",
               {in_ready, out_valid, busy, ram_we});
    end
    checks++;
    if ({out_flow_id, out_ftime, ram_w_addr, ram_din, ram_r_addr} !== '0) begin
      failures++;
      $display("FAIL reset_data: got flow=%0d ftime=%0d waddr=%0d din=%0d raddr=%0d expected all 0",
               out_flow_id, out_ftime, ram_w_addr, ram_din, ram_r_addr);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_init_clear();
    int cnt = 0;
    int nz = 0;
    clr_pulse();
    while (busy && cnt < 9000) begin cnt++; @(posedge clk); #1; end
    checks++;
    if (cnt != 8193) begin
      failures++;
      $display("FAIL init_clear_busy: got %0d busy cycles expected 8193", cnt);
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL init_clear_ram: got %0d nonzero entries expected 0", nz);
    end
  endtask

  task automatic test_basic();
    exp_t e, o;
    send(13'd5, 11'd100, 4'd0, 16'd50, 16'd150);
    checks++;
    if ({out_valid, ram_we} !== 2'b00) begin
      failures++;
      $display("FAIL basic_rd_state: got valid/we=%b expected 00", {out_valid, ram_we});
    end
    @(posedge clk); #1;
    checks++;
    if ({ram_we, ram_w_addr, ram_din, out_valid} !== {1'b1, 13'd5, 16'd150, 1'b0}) begin
      failures++;
      $display("FAIL basic_calc_write: got we=%0b addr=%0d din=%0d valid=%0b expected 1 5 150 0",
               ram_we, ram_w_addr, ram_din, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: got out_valid=%0b two cycles after accept expected 1", out_valid);
    end
    send(13'd5, 11'd20, 4'd0, 16'd60, 16'd170);
    send(13'd5, 11'd64, 4'd2, 16'd1000, 16'd1016);
    send(13'd12, 11'd2047, 4'd12, 16'd300, 16'd300);
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs[rd % 64]; rd++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_result: got flow=%0d ftime=%0d expected flow=%0d ftime=%0d",
                 o.flow, o.ftime, e.flow, e.ftime);
      end
    end
    checks++;
    if (mem[5] !== 16'd1016) begin
      failures++;
      $display("FAIL basic_ram5: got %0d expected 1016", mem[5]);
    end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    poke(13'd9, 16'd65530);
    send(13'd9, 11'd10, 4'd0, 16'd10, 16'd20);
    drain();
    poke(13'd9, 16'd65530);
    send(13'd9, 11'd10, 4'd0, 16'd65500, 16'd4);
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs[rd % 64]; rd++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap_result: got flow=%0d ftime=%0d expected flow=%0d ftime=%0d",
                 o.flow, o.ftime, e.flow, e.ftime);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int acc[2];
    int k = 0;
    int t = 0;
    exp_q.push_back('{flow: 13'd7, ftime: 16'd8});
    exp_q.push_back('{flow: 13'd7, ftime: 16'd16});
    in_valid = 1'b1; in_flow_id = 13'd7; in_len = 11'd8; in_w_shift = 4'd0; in_vtime = 16'd0;
    while (k < 2 && t < 50) begin
      if (in_ready) begin acc[k] = t; k++; end
      @(posedge clk); #1; t++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != 2 || acc[1] - acc[0] != 4) begin
      failures++;
      $display("FAIL b2b_spacing: got accepts=%0d spacing=%0d expected 2 and 4", k,
               (k == 2) ? acc[1] - acc[0] : -1);
    end
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs[rd % 64]; rd++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_result: got flow=%0d ftime=%0d expected flow=%0d ftime=%0d",
                 o.flow, o.ftime, e.flow, e.ftime);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e, o;
    int t = 0;
    int w0;
    int n0;
    out_ready = 1'b0;
    send(13'd11, 11'd40, 4'd3, 16'd100, 16'd105);
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    w0 = wr_cnt;
    n0 = n_obs;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_flow_id, out_ftime, in_ready} !== {1'b1, 13'd11, 16'd105, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d got valid=%0b flow=%0d ftime=%0d ready=%0b expected 1 11 105 0",
                 i, out_valid, out_flow_id, out_ftime, in_ready);
      end
    end
    checks++;
    if (wr_cnt != w0) begin
      failures++;
      $display("FAIL stall_writes: got %0d extra RAM writes expected 0", wr_cnt - w0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01 || n_obs != n0 + 1) begin
      failures++;
      $display("FAIL stall_release: got valid=%0b ready=%0b handshakes=%0d expected 0 1 1",
               out_valid, in_ready, n_obs - n0);
    end
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs[rd % 64]; rd++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall_result: got flow=%0d ftime=%0d expected flow=%0d ftime=%0d",
                 o.flow, o.ftime, e.flow, e.ftime);
      end
    end
  endtask

  task automatic test_clr_wins();
    exp_t e, o;
    int cnt = 0;
    int bad_ready = 0;
    int nz = 0;
    scramble = 1'b1;
    @(posedge clk); #1;
    scramble = 1'b0;
    exp_q.push_back('{flow: 13'd3, ftime: 16'd5});
    in_valid = 1'b1; in_flow_id = 13'd3; in_len = 11'd5; in_w_shift = 4'd0; in_vtime = 16'd0;
    clr = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clrwin_ready: got in_ready=%0b with clr and in_valid expected 0", in_ready);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    while (busy && cnt < 9000) begin
      if (in_ready) bad_ready++;
      cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 8193 || bad_ready != 0) begin
      failures++;
      $display("FAIL clrwin_busy: got busy=%0d ready_while_busy=%0d expected 8193 0", cnt, bad_ready);
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
    checks++;
    if (nz != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clrwin_after: got nonzero=%0d in_ready=%0b expected 0 1", nz, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs[rd % 64]; rd++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL clrwin_result: got flow=%0d ftime=%0d expected flow=%0d ftime=%0d",
                 o.flow, o.ftime, e.flow, e.ftime);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    clr_pulse();
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL sweep_busy: got busy=%0b mid-sweep expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, ram_we} !== 3'b010) begin
      failures++;
      $display("FAIL sweep_reset: got busy/ready/we=%b expected 010", {busy, in_ready, ram_we});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, ram_we} !== 2'b00) begin
      failures++;
      $display("FAIL sweep_aborted: got busy/we=%b after reset release expected 00", {busy, ram_we});
    end
  endtask

  initial begin
    in_valid = 1'b0; in_flow_id = '0; in_len = '0; in_w_shift = '0; in_vtime = '0;
    out_ready = 1'b1; clr = 1'b0; rst_n = 1'b0;
    scramble = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    test_reset();
    test_init_clear();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_clr_wins();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wfq_ftime_calc.md
# wfq_ftime_calc

Per-flow finish-time calculator for the WFQ scheduler. It sits directly upstream of the finish-time block RAM, which it both reads and writes. For each arriving packet it fetches the flow's previous finish time and computes start = later(vtime, prev_F) and F = start + (pkt_len >> w_shift). It writes F back to the RAM and presents (flow_id, F) to the sorter/dispatch stage over a valid/ready handshake. It also sweeps the RAM to zero on request.

## Interface
- N, 13, flow-id / RAM address width; finish-time width FW = N+3 (16 at default, matches RAM data width)
- L, 11, packet-length width (bytes)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  packet descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_flow_id  in  N  flow index
- in_len  in  L  packet length
- in_w_shift  in  4  weight as right-shift (weight = 2^w_shift)
- in_vtime  in  FW  current system virtual time
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_flow_id  out  N  flow index of result
- out_ftime  out  FW  new finish time
- clr  in  1  single-cycle pulse: zero all RAM entries
- busy  out  1  high while clear sweep runs or clear pending
- ram_we  out  1  RAM write enable
- ram_w_addr  out  N  RAM write address
- ram_r_addr  out  N  RAM read address
- ram_din  out  FW  RAM write data
- ram_dout  in  FW  RAM read data, registered (valid one cycle after ram_r_addr)

## Operation
- States: IDLE, RD, CALC, OUT, CLR.
- IDLE: in_ready=1 unless clear pending. On accept: capture flow_id, len, w_shift, vtime into registers → RD.
- RD: ram_r_addr = captured flow_id → CALC.
- CALC: prev = ram_dout. Serial compare: d = (vtime − prev) mod 2^FW; start = vtime if d[FW−1]==0, else prev. incr = zero-extend(len) >> w_shift (w_shift ≥ L gives 0). F = (start + incr) mod 2^FW. Assert ram_we, ram_w_addr = flow_id, ram_din = F. Load out_flow_id and out_ftime → OUT.
- OUT: out_valid=1; outputs held stable until out_ready → IDLE.
- clr pulse in any state sets a pending flag. In IDLE, pending clear takes priority over in_valid (in_ready=0) → CLR. Counter starts at 0.
- CLR: ram_we=1, ram_w_addr = counter, ram_din = 0; counter++ each cycle. After writing address 2^N−1 → IDLE, flag cleared. clr during CLR is ignored.
- busy = pending | (state==CLR).
- ram_we is 0 in all states other than CALC and CLR. ram_r_addr holds the captured flow_id in all states.

## Timing
- Reset (async assert, sync-released use): state IDLE. Outputs in_ready=1, out_valid=0, out_flow_id=0, out_ftime=0, busy=0, ram_we=0, ram_w_addr=0, ram_din=0, ram_r_addr=0. Counter and pending flag 0.
- Reset mid-operation aborts the packet or sweep. RAM contents are not reset; software issues clr after reset.
- Latency: accept at edge E0; RAM read at E1; write and output load at E2; out_valid high from E2.
- Throughput: with out_ready=1, one packet per 4 cycles.
- Read-after-write hazard: the write completes at E2, before the next possible RD. No forwarding is needed; a same-flow packet always sees the updated F.
- Clear sweep: 2^N cycles in CLR, plus 1 IDLE cycle if requested from IDLE.
- Width: all finish-time arithmetic is modulo 2^FW; overflow wraps silently.

## Test plan
- Reset, then clr and wait busy=0. Flow 5, len 100, shift 0, vtime 50 → out_ftime 150, RAM[5]=150. Flow 5, len 20, vtime 60 → 170.
- Prev RAM[5]=170, vtime 1000, len 64, shift 2 → start 1000, out_ftime 1016.
- Wrap cases:
  - RAM[9]=65530, vtime 10 → vtime serially later → len 10 gives 20.
  - RAM[9]=65530, vtime 65500, len 10 → 4 (modulo wrap).
- Back-to-back flow 7 (len 8, then len 8, vtime 0, cleared RAM), out_ready=1 → results 8 then 16. Accepts 4 cycles apart; in_ready low during RD/CALC/OUT.
- out_ready low 5 cycles in OUT → out_valid, out_flow_id, out_ftime stable; in_ready=0; no extra RAM write. Release → one handshake, then IDLE.
- Clear cases:
  - clr and in_valid same cycle in IDLE → clear wins; busy high 8193 cycles (N=13); all entries read 0 afterwards; descriptor accepted after.
  - rst_n low mid-sweep → IDLE, busy=0 immediately.
